// File: rtl/pll_clkdiv_seq.sv
// Lock sequencer and multi-channel aligned clock divider running on the vco-rate clock.
// Outputs stay quiet while in standby. After the lock interval, NCH phase-aligned divided
// clocks are released. Divider reload and per-channel re-entry are glitch-free.
module pll_clkdiv_seq #(
  parameter int unsigned NCH         = 3,
  parameter int unsigned DW          = 4,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              stby,
  input  logic [NCH-1:0]    ch_stby,
  input  logic [NCH*DW-1:0] div_in,
  input  logic              div_ld,
  output logic              div_ack,
  output logic [NCH-1:0]    clko,
  output logic              lock,
  output logic              align
);

  localparam int unsigned TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [NCH-1:0][DW-1:0]   div_in_a;
  logic [NCH-1:0][DW-1:0]   cnt_q;
  logic [NCH-1:0][DW-1:0]   div_cur_q;
  logic [NCH-1:0][DW-1:0]   div_pend_q;
  logic [NCH-1:0]           pend_vld_q;
  logic [NCH-1:0]           run_q;
  logic [NCH-1:0]           term_c;
  logic [NCH-1:0]           rise_c;
  logic [NCH-1:0]           start_c;
  logic                     ch0_start_c;
  logic                     entry_c;
  logic                     in_lock_c;

  assign div_in_a = div_in;

  // State and lock timer registers
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= S_OFF;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state: standby overrides everything, COUNT lasts LOCK_CYCLES cycles
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_OFF: begin
        timer_d = '0;
        if (!stby) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (timer_q == TW'(LOCK_CYCLES - 1)) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_LOCKED: timer_d = '0;
      default: begin
        state_d = S_OFF;
        timer_d = '0;
      end
    endcase
    if (stby) begin
      state_d = S_OFF;
      timer_d = '0;
    end
  end

  assign entry_c   = (state_q != S_LOCKED) && (state_d == S_LOCKED);
  assign in_lock_c = (state_q == S_LOCKED) && (state_d == S_LOCKED);

  // Terminal count and rising period boundary per channel
  always_comb begin
    term_c = '0;
    rise_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      term_c[i] = run_q[i] && (cnt_q[i] == div_cur_q[i]);
      rise_c[i] = term_c[i] && !clko[i];
    end
  end

  // Channel 0 starts a period on lock entry, at its boundary, or on standby release
  always_comb begin
    ch0_start_c = !ch_stby[0] &&
                  (entry_c || (in_lock_c && (!run_q[0] || rise_c[0])));
  end

  // Released channels wait for channel 0 to start a period (or go at once if it is parked)
  always_comb begin
    start_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (i == 0) begin
        start_c[i] = ch0_start_c;
      end else begin
        start_c[i] = !ch_stby[i] &&
                     (entry_c ||
                      (in_lock_c && !run_q[i] && (ch0_start_c || ch_stby[0])));
      end
    end
  end

  // Per-channel divide counters and output clocks
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt_q <= '0;
      clko  <= '0;
      run_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!(entry_c || in_lock_c) || ch_stby[i]) begin
          cnt_q[i] <= '0;
          clko[i]  <= 1'b0;
          run_q[i] <= 1'b0;
        end else if (start_c[i]) begin
          cnt_q[i] <= '0;
          clko[i]  <= 1'b1;
          run_q[i] <= 1'b1;
        end else if (run_q[i]) begin
          if (term_c[i]) begin
            cnt_q[i] <= '0;
            clko[i]  <= !clko[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + DW'(1);
          end
        end
      end
    end
  end

  // Divider capture; while locked each channel adopts the pending value at a later boundary
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      div_cur_q  <= '0;
      div_pend_q <= '0;
      pend_vld_q <= '0;
      div_ack    <= 1'b0;
    end else begin
      div_ack <= div_ld;
      if (div_ld) div_pend_q <= div_in_a;
      if (state_q != S_LOCKED) begin
        pend_vld_q <= '0;
        if (div_ld) begin
          div_cur_q <= div_in_a;
        end else begin
          for (int unsigned i = 0; i < NCH; i++) begin
            if (pend_vld_q[i]) div_cur_q[i] <= div_pend_q[i];
          end
        end
      end else begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (div_ld) begin
            pend_vld_q[i] <= 1'b1;
          end else if (pend_vld_q[i] && rise_c[i]) begin
            div_cur_q[i]  <= div_pend_q[i];
            pend_vld_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Registered lock flag and channel-0 period-start pulse
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      lock  <= 1'b0;
      align <= 1'b0;
    end else begin
      lock  <= (state_d == S_LOCKED);
      align <= ch0_start_c;
    end
  end

endmodule

// File: tb/tb_pll_clkdiv_seq.sv
// Directed scoreboard bench for pll_clkdiv_seq: expected output vectors come from a
// per-channel period formula (start cycle, divider) maintained by the stimulus steps.
module tb_pll_clkdiv_seq;

  localparam int unsigned NCH  = 3;
  localparam int unsigned DW   = 4;
  localparam int unsigned LOCK = 16;
  localparam int unsigned OW   = NCH + 3;

  logic              clk;
  logic              reset_l;
  logic              stby;
  logic [NCH-1:0]    ch_stby;
  logic [NCH*DW-1:0] div_in;
  logic              div_ld;
  logic              div_ack;
  logic [NCH-1:0]    clko;
  logic              lock;
  logic              align;

  typedef struct {
    string         tag;
    int            cyc;
    logic [OW-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   lk      = 0;
  logic e_lock;
  int   t0[NCH];
  int   dv[NCH];

  pll_clkdiv_seq #(.NCH(NCH), .DW(DW), .LOCK_CYCLES(LOCK)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .stby    (stby),
    .ch_stby (ch_stby),
    .div_in  (div_in),
    .div_ld  (div_ld),
    .div_ack (div_ack),
    .clko    (clko),
    .lock    (lock),
    .align   (align)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {div_ack, align, lock, clko} after edge c
  function automatic logic [OW-1:0] model(input int c);
    logic [NCH-1:0] ck;
    logic           al;
    int             per;
    ck = '0;
    for (int i = 0; i < NCH; i++) begin
      per = 2 * (dv[i] + 1);
      if (t0[i] >= 0 && c >= t0[i]) ck[i] = (((c - t0[i]) % per) < (dv[i] + 1));
    end
    per = 2 * (dv[0] + 1);
    al = (t0[0] >= 0) && (c >= t0[0]) && (((c - t0[0]) % per) == 0);
    return {div_ld, al, e_lock, ck};
  endfunction

  task automatic check_one();
    exp_t          e;
    logic [OW-1:0] obs;
    e   = exp_q.pop_front();
    obs = {div_ack, align, lock, clko};
    n_total++;
    assert (obs === e.val) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed {ack,align,lock,clko}=%b expected=%b",
             e.tag, e.cyc, obs, e.val);
    end
  endtask

  task automatic check_now(input string tag, input logic [OW-1:0] val);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc;
    e.val = val;
    exp_q.push_back(e);
    check_one();
  endtask

  task automatic run(input string tag, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.tag = tag;
      e.cyc = cyc + 1;
      e.val = model(cyc + 1);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      check_one();
    end
  endtask

  task automatic run_to(input string tag, input int target);
    while (cyc < target) run(tag, 1);
  endtask

  initial begin
    reset_l = 1'b1;
    stby    = 1'b1;
    ch_stby = '0;
    div_in  = '0;
    div_ld  = 1'b0;
    e_lock  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      t0[i] = -1;
      dv[i] = 0;
    end

    // Asynchronous reset, outputs quiet
    #1 reset_l = 1'b0;
    #2 check_now("reset", '0);
    @(negedge clk);
    reset_l = 1'b1;
    run("off", 2);

    // Load dividers {C,B,A}={2,1,0} while off, then release standby
    div_in = {4'd2, 4'd1, 4'd0};
    div_ld = 1'b1;
    run("ld_off", 1);
    div_ld = 1'b0;
    stby   = 1'b0;
    run("count", LOCK);
    lk     = cyc + 1;
    e_lock = 1'b1;
    for (int i = 0; i < NCH; i++) t0[i] = lk;
    dv[0] = 0; dv[1] = 1; dv[2] = 2;
    run("lock", 24);

    // Standby pulse mid-lock, reload A=3 while off, relock
    stby   = 1'b1;
    e_lock = 1'b0;
    for (int i = 0; i < NCH; i++) t0[i] = -1;
    run("stby", 1);
    div_in = {4'd2, 4'd1, 4'd3};
    div_ld = 1'b1;
    run("ld_stby", 1);
    div_ld = 1'b0;
    run("stby_hold", 1);
    stby = 1'b0;
    run("relock_cnt", LOCK);
    lk     = cyc + 1;
    e_lock = 1'b1;
    for (int i = 0; i < NCH; i++) t0[i] = lk;
    dv[0] = 3;
    run_to("lock2", lk + 2);

    // A=1 loaded mid-period: current 8-cycle period completes, then 4-cycle periods
    div_in = {4'd2, 4'd1, 4'd1};
    div_ld = 1'b1;
    run("ld_mid", 1);
    div_ld = 1'b0;
    run_to("a3_tail", lk + 7);
    t0[0] = lk + 8;
    dv[0] = 1;
    run_to("a1", lk + 12);

    // Two loads (A=5, then A=2) before the boundary: last one wins
    div_in = {4'd2, 4'd1, 4'd5};
    div_ld = 1'b1;
    run("ld5", 1);
    div_ld = 1'b0;
    run("gap", 1);
    div_in = {4'd2, 4'd1, 4'd2};
    div_ld = 1'b1;
    run("ld2", 1);
    div_ld = 1'b0;
    t0[0] = lk + 16;
    dv[0] = 2;
    run_to("a2", lk + 21);

    // Load coincident with a boundary: that boundary keeps the old divider
    div_in = {4'd2, 4'd1, 4'd3};
    div_ld = 1'b1;
    run("ld_coinc", 1);
    div_ld = 1'b0;
    run_to("coinc_old", lk + 27);
    t0[0] = lk + 28;
    dv[0] = 3;
    run_to("a3b", lk + 29);

    // Channel 1 standby for 10 cycles, released mid channel-0 period
    ch_stby = 3'b010;
    t0[1]   = -1;
    run_to("ch1_stby", lk + 39);
    ch_stby = 3'b000;
    t0[1]   = lk + 44;
    run_to("ch1_wait", lk + 49);

    // Channel 0 and 2 parked; channel 2 restarts at once, channel 0 on next edge
    ch_stby = 3'b101;
    t0[0]   = -1;
    t0[2]   = -1;
    run_to("ch02_stby", lk + 51);
    ch_stby = 3'b001;
    t0[2]   = lk + 52;
    run("ch2_rel", 1);
    ch_stby = 3'b000;
    t0[0]   = lk + 53;
    run_to("ch0_rel", lk + 64);

    // Asynchronous reset while locked
    #2 reset_l = 1'b0;
    #1 check_now("async_rst", '0);
    @(posedge clk);
    #1;
    check_now("rst_hold", '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
